// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 datapath stages (init, ksa, prga).
package rc4_pkg;

    typedef logic [7:0] byte_t;

    localparam int S_SIZE = 256;

    // Widest key the helper below accepts (32 bytes = 256 bits).
    localparam int KEY_W_MAX = 256;

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        CAP_I,
        RD_J,
        CAP_J,
        WR_I,
        WR_J
    } ksa_state_t;

    // Key is left-aligned in a KEY_W_MAX container; byte 0 is the top byte.
    function automatic byte_t key_byte(input logic [KEY_W_MAX-1:0] key, input int idx);
        return key[KEY_W_MAX-1-8*idx -: 8];
    endfunction

endpackage

// File: rtl/ksa_key_sel.sv
// Latched secret key plus wrapping key-byte index; presents the current key byte.
module ksa_key_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   advance,
    input  logic [8*KEY_BYTES-1:0] key,
    output byte_t                  kbyte
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    logic [KW-1:0]          k;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [KEY_W_MAX-1:0]   key_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k     <= '0;
            key_q <= '0;
        end else if (load) begin
            k     <= '0;
            key_q <= key;
        end else if (advance) begin
            // Wrapping counter stands in for i mod KEY_BYTES.
            k <= (k == KW'(KEY_BYTES - 1)) ? '0 : k + 1'b1;
        end
    end

    assign key_ext = KEY_W_MAX'(key_q) << (KEY_W_MAX - 8 * KEY_BYTES);
    assign kbyte   = key_byte(key_ext, int'(k));

endmodule

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the S array in an external 256x8 sync RAM.
module ksa
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    // Handshake: a start is accepted in any cycle where en && rdy; rdy drops
    // the following cycle and stays low until the permutation finishes.
    // en while rdy=0 is ignored, and key is only sampled on acceptance.

    ksa_state_t state, state_n;
    byte_t      i, i_n, j, j_n, si, si_n, sj, sj_n;
    byte_t      addr_n, wrdata_n;
    logic       rdy_n, wren_n;
    logic       key_load, key_adv;
    byte_t      kbyte;

    ksa_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
        .clk     (clk),
        .rst     (rst),
        .load    (key_load),
        .advance (key_adv),
        .key     (key),
        .kbyte   (kbyte)
    );

    always_comb begin
        state_n  = state;
        i_n      = i;
        j_n      = j;
        si_n     = si;
        sj_n     = sj;
        key_load = 1'b0;
        key_adv  = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_n  = RD_I;
                    i_n      = 8'd0;
                    j_n      = 8'd0;
                    key_load = 1'b1;
                end
            end
            RD_I:  state_n = CAP_I;
            CAP_I: begin
                si_n    = rddata;
                j_n     = j + rddata + kbyte;
                state_n = RD_J;
            end
            RD_J:  state_n = CAP_J;
            CAP_J: begin
                sj_n    = rddata;
                state_n = WR_I;
            end
            WR_I:  state_n = WR_J;
            WR_J: begin
                if (i == 8'hFF) begin
                    state_n = IDLE;
                end else begin
                    i_n     = i + 8'd1;
                    key_adv = 1'b1;
                    state_n = RD_I;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered
    // alongside it and line up with the state they belong to.
    always_comb begin
        rdy_n    = (state_n == IDLE);
        wren_n   = (state_n == WR_I) || (state_n == WR_J);
        addr_n   = addr;
        wrdata_n = wrdata;

        case (state_n)
            RD_I:  addr_n = i_n;
            RD_J:  addr_n = j_n;
            WR_I: begin
                addr_n   = i_n;
                wrdata_n = sj_n;
            end
            WR_J: begin
                addr_n   = j_n;
                wrdata_n = si_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            i      <= 8'd0;
            j      <= 8'd0;
            si     <= 8'd0;
            sj     <= 8'd0;
            rdy    <= 1'b1;
            wren   <= 1'b0;
            addr   <= 8'd0;
            wrdata <= 8'd0;
        end else begin
            state  <= state_n;
            i      <= i_n;
            j      <= j_n;
            si     <= si_n;
            sj     <= sj_n;
            rdy    <= rdy_n;
            wren   <= wren_n;
            addr   <= addr_n;
            wrdata <= wrdata_n;
        end
    end

endmodule

// File: tb/tb_ksa.sv
// Self-checking bench for ksa: directed vector table plus reset/handshake sequences.
module tb_ksa;

    localparam int KB = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [8*KB-1:0] key = '0;
    logic          rdy;
    logic [7:0]    addr;
    logic [7:0]    rddata;
    logic [7:0]    wrdata;
    logic          wren;

    logic [7:0]    mem [256];
    logic [7:0]    exp_mem [256];
    logic          load_id = 1'b0;

    logic [15:0]   exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            wr_cnt = 0;
    int            busy_cnt = 0;

    typedef struct {
        logic [23:0] key;
        logic [15:0] w [6];
    } vec_t;

    vec_t vecs [3];

    ksa #(.KEY_BYTES(KB)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
    );

    // clock / RAM model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_id) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        end else if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor + scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (!rdy) busy_cnt++;
            if (wren) begin
                wr_cnt++;
                if (exp_q.size() > 0) check("write_seq", {addr, wrdata}, exp_q.pop_front());
            end
        end
    end

    // software KSA straight from the textbook definition
    function automatic void ksa_model(input logic [23:0] k);
        logic [7:0] jm, t;
        jm = 8'd0;
        for (int n = 0; n < 256; n++) exp_mem[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            jm = jm + exp_mem[n] + k[23-8*(n%3) -: 8];
            t = exp_mem[n];
            exp_mem[n] = exp_mem[jm];
            exp_mem[jm] = t;
        end
    endfunction

    // driver tasks
    task automatic load_identity();
        @(negedge clk) load_id = 1'b1;
        @(negedge clk) load_id = 1'b0;
    endtask

    task automatic start_run(input logic [23:0] k, input bit hold);
        @(negedge clk);
        en = 1'b1;
        key = k;
        wr_cnt = 0;
        busy_cnt = 0;
        @(negedge clk);
        if (!hold) en = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!rdy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_ram(input logic [23:0] k, input string tag);
        int mism = 0;
        int distinct = 0;
        bit seen [256];
        ksa_model(k);
        for (int n = 0; n < 256; n++) seen[n] = 1'b0;
        for (int n = 0; n < 256; n++) begin
            if (mem[n] !== exp_mem[n]) mism++;
            if (!seen[mem[n]]) begin
                seen[mem[n]] = 1'b1;
                distinct++;
            end
        end
        check({tag, "_ram_vs_model"}, mism, 0);
        check({tag, "_permutation"}, distinct, 256);
    endtask

    task automatic check_run(input logic [23:0] k, input string tag);
        check({tag, "_busy_cycles"}, busy_cnt, 1536);
        check({tag, "_write_count"}, wr_cnt, 512);
        check({tag, "_exp_q_drained"}, exp_q.size(), 0);
        check_ram(k, tag);
    endtask

    initial begin
        int bad;
        int snap;

        vecs[0].key = 24'h00033C;
        vecs[0].w   = '{16'h0000, 16'h0000, 16'h0104, 16'h0401, 16'h0242, 16'h4202};
        vecs[1].key = 24'h000000;
        vecs[1].w   = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
        vecs[2].key = 24'h010203;
        vecs[2].w   = '{16'h0001, 16'h0100, 16'h0103, 16'h0300, 16'h0208, 16'h0802};

        // reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_rdy", rdy, 1);
        check("reset_wren", wren, 0);
        check("reset_addr", addr, 0);
        check("reset_wrdata", wrdata, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rdy !== 1'b1 || wren !== 1'b0) bad++;
        end
        check("idle_stable", bad, 0);
        check("idle_no_writes", wr_cnt, 0);

        // vector table: first writes plus full-run result
        foreach (vecs[v]) begin
            load_identity();
            for (int n = 0; n < 6; n++) exp_q.push_back(vecs[v].w[n]);
            start_run(vecs[v].key, 1'b0);
            wait_done();
            check_run(vecs[v].key, $sformatf("vec%0d", v));
        end

        // en and key disturbed mid-run must be ignored
        load_identity();
        start_run(24'h00033C, 1'b0);
        repeat (300) @(negedge clk);
        key = 24'hFFFFFF;
        en = 1'b1;
        repeat (3) @(negedge clk);
        en = 1'b0;
        wait_done();
        check_run(24'h00033C, "midrun");

        // en held high: restart the cycle rdy returns
        load_identity();
        start_run(24'h010203, 1'b1);
        wait_done();
        check_run(24'h010203, "held");
        busy_cnt = 0;
        @(negedge clk);
        check("held_restart", rdy, 0);
        en = 1'b0;

        // async reset mid-run, around cycle 700, landing on a write cycle
        bad = 0;
        while (busy_cnt < 700 && bad < 2000) begin
            @(negedge clk);
            bad++;
        end
        bad = 0;
        while (!wren && bad < 10) begin
            @(negedge clk);
            bad++;
        end
        check("abort_in_write", wren, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_rdy_now", rdy, 1);
        check("abort_wren_now", wren, 0);
        snap = wr_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_writes", wr_cnt, snap);
        check("abort_idle", rdy, 1);

        // fresh run after abort starts from i=j=0
        load_identity();
        for (int n = 0; n < 6; n++) exp_q.push_back(vecs[0].w[n]);
        start_run(vecs[0].key, 1'b0);
        wait_done();
        check_run(vecs[0].key, "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
